rl_fifo_1r1w_ctrl: RTL and testbench
====================================

Name: rl_fifo_1r1w_ctrl

Overview:
- Synchronous first-word-fall-through FIFO controller that drives an external 1R1W block RAM through its write and read ports, and consumes the RAM's registered read data.
- Presents valid/ready streaming interfaces on both sides.
- Hides the RAM's 1-cycle read latency with a 2-entry output skid buffer, so sustained throughput is 1 word/cycle.
- Sits between a producer stream and any 1R1W RAM with 2^ABITS words and registered output.

Parameters:
ABITS, 10, RAM address bits; RAM depth DEPTH = 2^ABITS
DBITS, 32, data width
AFULL_LVL, 2^ABITS-4, almost-full threshold (RL_FIFO_LEVEL_EN only)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
flush_i  in  1  synchronous clear of all contents
wdata_i  in  DBITS  write data
wvalid_i  in  1  write request
wready_o  out  1  space available in RAM
rdata_o  out  DBITS  head-of-FIFO data
rvalid_o  out  1  rdata_o valid
rready_i  in  1  consumer accepts rdata_o
ram_waddr_o  out  ABITS  RAM write address
ram_din_o  out  DBITS  RAM write data (= wdata_i)
ram_we_o  out  1  RAM write enable
ram_be_o  out  (DBITS+7)/8  RAM byte enables, all ones
ram_raddr_o  out  ABITS  RAM read address
ram_dout_i  in  DBITS  RAM read data, valid 1 cycle after ram_raddr_o is sampled
level_o  out  ABITS+2  total occupancy (RL_FIFO_LEVEL_EN only)
almost_full_o  out  1  level_o >= AFULL_LVL (RL_FIFO_LEVEL_EN only)

Behaviour:
- Interface: one clock (clk_i); reset rst_i is asynchronous and active-high.
- Reset values:
  - wptr, rptr, ram_cnt, buf_cnt, inflight: 0.
  - rvalid_o, rdata_o, level_o, almost_full_o: 0.
  - wready_o: 0 (registered); it goes to 1 on the first edge after rst_i deasserts.
- Write path:
  - push = wvalid_i & wready_o.
  - ram_we_o = push; ram_waddr_o = wptr; wptr increments on push and wraps modulo DEPTH.
  - wready_o is registered: wready_o = (ram_cnt_next != DEPTH).
- Read issue:
  - pop = rvalid_o & rready_i.
  - issue = (ram_cnt != 0) & (buf_cnt + inflight - pop < 2).
  - ram_raddr_o = rptr; rptr increments on issue and wraps modulo DEPTH.
  - inflight <= issue.
- Capture: when inflight = 1, ram_dout_i is written into the skid buffer (2 entries, in-order); the head entry drives rdata_o; rvalid_o = (buf_cnt != 0).
- ram_cnt_next = ram_cnt + push - issue. The RAM never holds more than DEPTH words.
- Latency: a write accepted at edge E0 into an empty FIFO gives rvalid_o = 1 after edge E2 (2 cycles).
- Read/write collision: a read is never issued to a word in the cycle it is written, because ram_cnt counts only committed words.
- Simultaneous push and issue when ram_cnt = DEPTH: not possible, since wready_o = 0.
- Simultaneous push and pop when full: pop frees buffer space, issue fires, and wready_o rises the next cycle.
- flush_i:
  - Synchronously clears all counters, pointers, inflight and buffer; on the next cycle rvalid_o = 0 and wready_o = 1.
  - flush_i wins over a same-cycle push or pop; both are discarded.
  - Data returning from an in-flight read is dropped.
- Reset mid-transfer: all state is cleared immediately and in-flight data is dropped.
- Total capacity: DEPTH + 2 words.

Optional Feature:
- Macro RL_FIFO_LEVEL_EN.
- Defined:
  - level_o = ram_cnt + buf_cnt + inflight, registered and updated every cycle.
  - almost_full_o = (level_o >= AFULL_LVL), registered.
- Undefined: level_o and almost_full_o are tied to 0 and no occupancy adder is built.

Test Plan (ABITS=4, DBITS=8, DEPTH=16):
- Single word: write 0xA5 at E0 -> rvalid_o=1 with rdata_o=0xA5 after E2; pop -> rvalid_o=0 next cycle.
- Fill: 18 writes with rready_i=0 -> wready_o=0 after the 18th (16 in RAM, 2 in buffer); a further wvalid_i is not accepted; level_o=18.
- Streaming: continuous writes 0x00..0x3F with rready_i=1 -> all 64 values read out in order, no bubbles after the first valid, no loss.
- Wrap: alternate 10-word bursts with random rready_i for 100 words -> pointers wrap at 16 and the output order is unchanged.
- Backpressure: toggle rready_i every cycle during streaming -> no duplicated or dropped words; rdata_o holds stable while rvalid_o=1 and rready_i=0.
- Flush/reset: write 5 words, then assert flush_i together with wvalid_i (data 0x77) -> next cycle rvalid_o=0, level_o=0, 0x77 never appears. Repeat with rst_i asserted mid-read -> the same empty state.

Source files
------------

// File: rtl/rl_fifo_1r1w_ctrl.sv
// First-word-fall-through FIFO controller for an external 1R1W RAM with registered output.
// Define RL_FIFO_LEVEL_EN to build the registered level_o / almost_full_o occupancy outputs.
module rl_fifo_1r1w_ctrl #(
    parameter int ABITS     = 10,
    parameter int DBITS     = 32,
    parameter int AFULL_LVL = 2**ABITS - 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic [DBITS-1:0]       wdata_i,
    input  logic                   wvalid_i,
    output logic                   wready_o,
    output logic [DBITS-1:0]       rdata_o,
    output logic                   rvalid_o,
    input  logic                   rready_i,
    output logic [ABITS-1:0]       ram_waddr_o,
    output logic [DBITS-1:0]       ram_din_o,
    output logic                   ram_we_o,
    output logic [(DBITS+7)/8-1:0] ram_be_o,
    output logic [ABITS-1:0]       ram_raddr_o,
    input  logic [DBITS-1:0]       ram_dout_i,
    output logic [ABITS+1:0]       level_o,
    output logic                   almost_full_o
);
    localparam int DEPTH = 2**ABITS;
    localparam logic [ABITS:0] DEPTH_CNT = (ABITS+1)'(DEPTH);

    // Reject thresholds the occupancy counter can never reach.
    if (AFULL_LVL < 0 || AFULL_LVL > DEPTH + 2) begin : g_bad_afull
        $error("AFULL_LVL out of range");
    end

    logic [ABITS-1:0] wptr, rptr;
    logic [ABITS:0]   ram_cnt, ram_cnt_next;
    logic [1:0]       buf_cnt, buf_cnt_next;
    logic             inflight;
    logic [DBITS-1:0] buf0, buf1;
    logic             push, pop, issue;
    logic [2:0]       buf_occ;

    // A flush cycle discards both the incoming word and the consumer's acceptance.
    assign push         = wvalid_i & wready_o & ~flush_i;
    assign pop          = rvalid_o & rready_i & ~flush_i;
    assign buf_occ      = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign issue        = (ram_cnt != '0) && (buf_occ < 3'd2);
    assign ram_cnt_next = ram_cnt + {{ABITS{1'b0}}, push} - {{ABITS{1'b0}}, issue};
    assign buf_cnt_next = buf_cnt + {1'b0, inflight} - {1'b0, pop};

    assign ram_we_o    = push;
    assign ram_waddr_o = wptr;
    assign ram_din_o   = wdata_i;
    assign ram_be_o    = '1;
    assign ram_raddr_o = rptr;
    assign rvalid_o    = (buf_cnt != 2'd0);
    assign rdata_o     = buf0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr     <= '0;
            rptr     <= '0;
            ram_cnt  <= '0;
            buf_cnt  <= '0;
            inflight <= 1'b0;
            buf0     <= '0;
            buf1     <= '0;
            wready_o <= 1'b0;
        end else if (flush_i) begin
            wptr     <= '0;
            rptr     <= '0;
            ram_cnt  <= '0;
            buf_cnt  <= '0;
            inflight <= 1'b0;
            buf0     <= '0;
            buf1     <= '0;
            wready_o <= 1'b1;
        end else begin
            if (push) wptr <= wptr + ABITS'(1);
            if (issue) rptr <= rptr + ABITS'(1);
            ram_cnt  <= ram_cnt_next;
            buf_cnt  <= buf_cnt_next;
            inflight <= issue;
            wready_o <= (ram_cnt_next != DEPTH_CNT);
            // Returning RAM data lands behind whatever survives this cycle's pop.
            case ({pop, inflight})
                2'b11: begin
                    if (buf_cnt == 2'd2) begin
                        buf0 <= buf1;
                        buf1 <= ram_dout_i;
                    end else begin
                        buf0 <= ram_dout_i;
                    end
                end
                2'b10: buf0 <= buf1;
                2'b01: begin
                    if (buf_cnt == 2'd0) buf0 <= ram_dout_i;
                    else                 buf1 <= ram_dout_i;
                end
                default: ;
            endcase
        end
    end

`ifdef RL_FIFO_LEVEL_EN
    logic [ABITS+1:0] level_next;
    localparam logic [ABITS+1:0] AFULL_CMP = (ABITS+2)'(AFULL_LVL);

    // Registered from next-state values so level_o matches the current contents.
    assign level_next = {1'b0, ram_cnt_next} + {{ABITS{1'b0}}, buf_cnt_next}
                      + {{(ABITS+1){1'b0}}, issue};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            level_o       <= '0;
            almost_full_o <= 1'b0;
        end else if (flush_i) begin
            level_o       <= '0;
            almost_full_o <= 1'b0;
        end else begin
            level_o       <= level_next;
            almost_full_o <= (level_next >= AFULL_CMP);
        end
    end
`else
    assign level_o       = '0;
    assign almost_full_o = 1'b0;
`endif

endmodule

// File: tb/tb_rl_fifo_1r1w_ctrl.sv
// Directed bench for rl_fifo_1r1w_ctrl (ABITS=4, DBITS=8) with a behavioural registered-output RAM.
module tb_rl_fifo_1r1w_ctrl;
    localparam int ABITS = 4;
    localparam int DBITS = 8;
    localparam int DEPTH = 16;
`ifdef RL_FIFO_LEVEL_EN
    localparam bit LVL_EN = 1'b1;
`else
    localparam bit LVL_EN = 1'b0;
`endif

    logic             clk_i = 1'b0;
    logic             rst_i, flush_i, wvalid_i, rready_i;
    logic [DBITS-1:0] wdata_i, rdata_o, ram_din_o, ram_dout_i;
    logic             wready_o, rvalid_o, ram_we_o, almost_full_o;
    logic [ABITS-1:0] ram_waddr_o, ram_raddr_o;
    logic [0:0]       ram_be_o;
    logic [ABITS+1:0] level_o;
    logic [DBITS-1:0] mem [DEPTH];

    int total = 0;
    int bad   = 0;

    rl_fifo_1r1w_ctrl #(.ABITS(ABITS), .DBITS(DBITS)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .wdata_i(wdata_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
        .rdata_o(rdata_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
        .ram_waddr_o(ram_waddr_o), .ram_din_o(ram_din_o), .ram_we_o(ram_we_o),
        .ram_be_o(ram_be_o), .ram_raddr_o(ram_raddr_o), .ram_dout_i(ram_dout_i),
        .level_o(level_o), .almost_full_o(almost_full_o)
    );

    always #5 clk_i = ~clk_i;

    // RAM model: synchronous write, registered read data one cycle after the address.
    always @(posedge clk_i) begin
        if (ram_we_o) mem[ram_waddr_o] <= ram_din_o;
        ram_dout_i <= mem[ram_raddr_o];
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; flush_i = 1'b0; wvalid_i = 1'b0; rready_i = 1'b0; wdata_i = '0;
        repeat (2) tick();
        total++; if (wready_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_wready: got %0b expected 0", wready_o); end
        total++; if (rvalid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_rvalid: got %0b expected 0", rvalid_o); end
        total++; if (rdata_o !== 8'h00) begin bad++; $display("[TB] FAIL reset_rdata: got %0h expected 0", rdata_o); end
        total++; if (level_o !== 6'd0) begin bad++; $display("[TB] FAIL reset_level: got %0d expected 0", level_o); end
        total++; if (almost_full_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_afull: got %0b expected 0", almost_full_o); end
        total++; if (ram_be_o !== 1'b1) begin bad++; $display("[TB] FAIL ram_be: got %0b expected 1", ram_be_o); end
        rst_i = 1'b0;
        tick();
        total++; if (wready_o !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_wready: got %0b expected 1", wready_o); end
        total++; if (rvalid_o !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_rvalid: got %0b expected 0", rvalid_o); end
    endtask

    task automatic test_single_word();
        wvalid_i = 1'b1; wdata_i = 8'hA5; rready_i = 1'b0;
        tick();
        wvalid_i = 1'b0;
        total++; if (ram_waddr_o !== 4'd1) begin bad++; $display("[TB] FAIL single_wptr: got %0d expected 1", ram_waddr_o); end
        total++; if (rvalid_o !== 1'b0) begin bad++; $display("[TB] FAIL single_e0_rvalid: got %0b expected 0", rvalid_o); end
        tick();
        total++; if (rvalid_o !== 1'b0) begin bad++; $display("[TB] FAIL single_e1_rvalid: got %0b expected 0", rvalid_o); end
        tick();
        total++; if (rvalid_o !== 1'b1) begin bad++; $display("[TB] FAIL single_e2_rvalid: got %0b expected 1", rvalid_o); end
        total++; if (rdata_o !== 8'hA5) begin bad++; $display("[TB] FAIL single_e2_rdata: got %0h expected a5", rdata_o); end
        total++; if (level_o !== (LVL_EN ? 6'd1 : 6'd0)) begin bad++; $display("[TB] FAIL single_level: got %0d expected %0d", level_o, LVL_EN ? 1 : 0); end
        rready_i = 1'b1;
        tick();
        rready_i = 1'b0;
        total++; if (rvalid_o !== 1'b0) begin bad++; $display("[TB] FAIL single_pop_rvalid: got %0b expected 0", rvalid_o); end
        total++; if (level_o !== 6'd0) begin bad++; $display("[TB] FAIL single_pop_level: got %0d expected 0", level_o); end
    endtask

    // wmode: 0 continuous writes, 1 ten-cycle bursts with gaps, 2 no writes (drain only).
    // rmode: 0 always ready, 1 toggle each cycle, 2 random.
    task automatic run_stream(input int n, input logic [7:0] base, input int rmode,
                              input int wmode, input string name);
        int sent = 0;
        int got = 0;
        int cyc = 0;
        logic seen = 1'b0;
        logic stalled = 1'b0;
        logic [7:0] held = '0;
        logic [7:0] expv;
        while (got < n && cyc < n * 25 + 100) begin
            wvalid_i = (wmode != 2) && (sent < n) && (wmode == 0 || (cyc % 20) < 10);
            wdata_i  = base + 8'(sent);
            case (rmode)
                0:       rready_i = 1'b1;
                1:       rready_i = cyc[0];
                default: rready_i = 1'($urandom_range(0, 1));
            endcase
            if (stalled) begin
                total++;
                if (rvalid_o !== 1'b1 || rdata_o !== held) begin
                    bad++;
                    $display("[TB] FAIL %s_hold: got v=%0b d=%0h expected v=1 d=%0h", name, rvalid_o, rdata_o, held);
                end
            end
            if (rmode == 0 && seen) begin
                total++;
                if (rvalid_o !== 1'b1) begin bad++; $display("[TB] FAIL %s_bubble: got rvalid=%0b expected 1 at word %0d", name, rvalid_o, got); end
            end
            if (rvalid_o && rready_i) begin
                expv = base + 8'(got);
                total++;
                if (rdata_o !== expv) begin bad++; $display("[TB] FAIL %s_data: got %0h expected %0h", name, rdata_o, expv); end
                got++;
            end
            if (rvalid_o) seen = 1'b1;
            stalled = rvalid_o && !rready_i;
            held = rdata_o;
            if (wvalid_i && wready_o) sent++;
            tick();
            cyc++;
        end
        wvalid_i = 1'b0; rready_i = 1'b0;
        total++;
        if (got != n) begin bad++; $display("[TB] FAIL %s_count: got %0d words expected %0d", name, got, n); end
    endtask

    task automatic test_fill();
        rready_i = 1'b0;
        for (int i = 0; i < 18; i++) begin
            total++;
            if (wready_o !== 1'b1) begin bad++; $display("[TB] FAIL fill_wready_%0d: got %0b expected 1", i, wready_o); end
            wvalid_i = 1'b1; wdata_i = 8'h10 + 8'(i);
            tick();
        end
        wvalid_i = 1'b0;
        total++; if (wready_o !== 1'b0) begin bad++; $display("[TB] FAIL fill_full_wready: got %0b expected 0", wready_o); end
        total++; if (level_o !== (LVL_EN ? 6'd18 : 6'd0)) begin bad++; $display("[TB] FAIL fill_level: got %0d expected %0d", level_o, LVL_EN ? 18 : 0); end
        total++; if (almost_full_o !== LVL_EN) begin bad++; $display("[TB] FAIL fill_afull: got %0b expected %0b", almost_full_o, LVL_EN); end
        wvalid_i = 1'b1; wdata_i = 8'hEE;
        for (int i = 0; i < 2; i++) begin
            total++; if (ram_we_o !== 1'b0) begin bad++; $display("[TB] FAIL fill_reject_we: got %0b expected 0", ram_we_o); end
            tick();
            total++; if (wready_o !== 1'b0) begin bad++; $display("[TB] FAIL fill_reject_wready: got %0b expected 0", wready_o); end
        end
        wvalid_i = 1'b0;
        total++; if (rdata_o !== 8'h10) begin bad++; $display("[TB] FAIL fill_head: got %0h expected 10", rdata_o); end
        rready_i = 1'b1;
        tick();
        rready_i = 1'b0;
        total++; if (wready_o !== 1'b1) begin bad++; $display("[TB] FAIL fill_pop_wready: got %0b expected 1", wready_o); end
        run_stream(17, 8'h11, 0, 2, "fill_drain");
    endtask

    task automatic test_flush();
        rready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wvalid_i = 1'b1; wdata_i = 8'h30 + 8'(i);
            tick();
        end
        flush_i = 1'b1; wvalid_i = 1'b1; wdata_i = 8'h77;
        tick();
        flush_i = 1'b0; wvalid_i = 1'b0;
        total++; if (rvalid_o !== 1'b0) begin bad++; $display("[TB] FAIL flush_rvalid: got %0b expected 0", rvalid_o); end
        total++; if (wready_o !== 1'b1) begin bad++; $display("[TB] FAIL flush_wready: got %0b expected 1", wready_o); end
        total++; if (level_o !== 6'd0) begin bad++; $display("[TB] FAIL flush_level: got %0d expected 0", level_o); end
        for (int i = 0; i < 4; i++) begin
            total++; if (rvalid_o !== 1'b0) begin bad++; $display("[TB] FAIL flush_quiet: got rvalid=%0b d=%0h expected 0", rvalid_o, rdata_o); end
            tick();
        end
        // Flush while a RAM read is in flight: the returning word must be dropped.
        wvalid_i = 1'b1; wdata_i = 8'h66;
        tick();
        wvalid_i = 1'b0;
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++; if (rvalid_o !== 1'b0) begin bad++; $display("[TB] FAIL flush_inflight: got rvalid=%0b d=%0h expected 0", rvalid_o, rdata_o); end
            tick();
        end
        run_stream(4, 8'h50, 0, 0, "post_flush");
    endtask

    task automatic test_reset_mid_read();
        rready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wvalid_i = 1'b1; wdata_i = 8'h40 + 8'(i);
            tick();
        end
        wvalid_i = 1'b0;
        rst_i = 1'b1;
        #1;
        total++; if (rvalid_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_rvalid: got %0b expected 0", rvalid_o); end
        total++; if (wready_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_wready: got %0b expected 0", wready_o); end
        rst_i = 1'b0;
        tick();
        total++; if (wready_o !== 1'b1) begin bad++; $display("[TB] FAIL rst_mid_wready_rise: got %0b expected 1", wready_o); end
        total++; if (level_o !== 6'd0) begin bad++; $display("[TB] FAIL rst_mid_level: got %0d expected 0", level_o); end
        for (int i = 0; i < 3; i++) begin
            total++; if (rvalid_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_quiet: got rvalid=%0b d=%0h expected 0", rvalid_o, rdata_o); end
            tick();
        end
        rready_i = 1'b0;
        run_stream(4, 8'h60, 0, 0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_fill();
        run_stream(64, 8'h00, 0, 0, "stream");
        run_stream(40, 8'h80, 1, 0, "backpressure");
        run_stream(100, 8'h10, 2, 1, "wrap");
        test_flush();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
